// File: rtl/peripheral_gpio_apb4.sv
// APB4 GPIO peripheral.
//
// PDATA_SIZE-bit general-purpose I/O port behind a zero-wait-state APB4 slave.
// It provides per-bit direction control, a two-flop input synchroniser and
// per-bit level or edge interrupt triggers.
//
// Register index = PADDR >> log2(PDATA_SIZE/8):
//   0 DIR (RW), 1 OUT (RW), 2 IN (RO), 3 TTYPE (RW, 0=level 1=edge),
//   4 TLVL0 (RW, low/falling), 5 TLVL1 (RW, high/rising), 6 TSTAT (W1C),
//   7 IRQEN (RW). Index 8 and above is unmapped (PSLVERR, reads return 0).
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   PSEL .. PWDATA         APB4 request
//   PRDATA/PREADY/PSLVERR  APB4 response (PREADY tied high)
//   gpio_i                 asynchronous pad inputs
//   gpio_o / gpio_oe       pad output values / output enables (1=drive)
//   irq_o                  registered interrupt request
module peripheral_gpio_apb4 #(
  parameter int unsigned PADDR_SIZE = 4,
  parameter int unsigned PDATA_SIZE = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic [PDATA_SIZE-1:0]   gpio_o,
  output logic [PDATA_SIZE-1:0]   gpio_oe,
  output logic                    irq_o
);

  localparam int unsigned NumLanes = PDATA_SIZE / 8;
  localparam int unsigned IdxLsb   = $clog2(NumLanes);

  localparam logic [2:0] IdxDir   = 3'd0;
  localparam logic [2:0] IdxOut   = 3'd1;
  localparam logic [2:0] IdxIn    = 3'd2;
  localparam logic [2:0] IdxTtype = 3'd3;
  localparam logic [2:0] IdxTlvl0 = 3'd4;
  localparam logic [2:0] IdxTlvl1 = 3'd5;
  localparam logic [2:0] IdxTstat = 3'd6;
  localparam logic [2:0] IdxIrqen = 3'd7;

  // Register state
  logic [PDATA_SIZE-1:0] dir_q,   dir_d;
  logic [PDATA_SIZE-1:0] out_q,   out_d;
  logic [PDATA_SIZE-1:0] ttype_q, ttype_d;
  logic [PDATA_SIZE-1:0] tlvl0_q, tlvl0_d;
  logic [PDATA_SIZE-1:0] tlvl1_q, tlvl1_d;
  logic [PDATA_SIZE-1:0] tstat_q, tstat_d;
  logic [PDATA_SIZE-1:0] irqen_q, irqen_d;
  logic                  irq_q,   irq_d;

  // Input path: sync1 -> in (sync2) -> prev
  logic [PDATA_SIZE-1:0] sync1_q;
  logic [PDATA_SIZE-1:0] in_q;
  logic [PDATA_SIZE-1:0] prev_q;

  // Address decode
  logic [PADDR_SIZE-1:0] idx;
  logic [2:0]            reg_sel;
  logic                  mapped;
  logic                  wr_en;
  logic [PDATA_SIZE-1:0] wmask;
  logic [PDATA_SIZE-1:0] wclr;

  // Trigger logic
  logic [PDATA_SIZE-1:0] rise;
  logic [PDATA_SIZE-1:0] fall;
  logic [PDATA_SIZE-1:0] lvl_set;
  logic [PDATA_SIZE-1:0] edge_set;
  logic [PDATA_SIZE-1:0] trig_set;

  assign idx     = PADDR >> IdxLsb;
  assign reg_sel = idx[2:0];
  assign mapped  = ((idx >> 3) == '0);

  // Erroring (unmapped) writes must leave all state untouched.
  assign wr_en = PSEL & PENABLE & PWRITE & mapped;

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      wmask[i*8 +: 8] = {8{PSTRB[i]}};
    end
  end

  assign wclr = (wr_en && (reg_sel == IdxTstat)) ? (PWDATA & wmask) : '0;

  assign rise     = in_q & ~prev_q;
  assign fall     = ~in_q & prev_q;
  assign lvl_set  = (tlvl1_q & in_q) | (tlvl0_q & ~in_q);
  assign edge_set = (tlvl1_q & rise) | (tlvl0_q & fall);
  assign trig_set = (ttype_q & edge_set) | (~ttype_q & lvl_set);

  // Next-state for the software-visible registers
  always_comb begin
    dir_d   = dir_q;
    out_d   = out_q;
    ttype_d = ttype_q;
    tlvl0_d = tlvl0_q;
    tlvl1_d = tlvl1_q;
    irqen_d = irqen_q;
    if (wr_en) begin
      case (reg_sel)
        IdxDir:   dir_d   = (dir_q   & ~wmask) | (PWDATA & wmask);
        IdxOut:   out_d   = (out_q   & ~wmask) | (PWDATA & wmask);
        IdxTtype: ttype_d = (ttype_q & ~wmask) | (PWDATA & wmask);
        IdxTlvl0: tlvl0_d = (tlvl0_q & ~wmask) | (PWDATA & wmask);
        IdxTlvl1: tlvl1_d = (tlvl1_q & ~wmask) | (PWDATA & wmask);
        IdxIrqen: irqen_d = (irqen_q & ~wmask) | (PWDATA & wmask);
        default:  ;
      endcase
    end
    // Set is applied after the clear so a colliding event keeps the bit set.
    tstat_d = (tstat_q & ~wclr) | trig_set;
    irq_d   = |(tstat_q & irqen_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dir_q   <= '0;
      out_q   <= '0;
      ttype_q <= '0;
      tlvl0_q <= '0;
      tlvl1_q <= '0;
      tstat_q <= '0;
      irqen_q <= '0;
      irq_q   <= 1'b0;
      sync1_q <= '0;
      in_q    <= '0;
      prev_q  <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      ttype_q <= ttype_d;
      tlvl0_q <= tlvl0_d;
      tlvl1_q <= tlvl1_d;
      tstat_q <= tstat_d;
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
      sync1_q <= gpio_i;
      in_q    <= sync1_q;
      prev_q  <= in_q;
    end
  end

  // Read mux: valid whenever a read is selected, including the setup phase.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && mapped) begin
      case (reg_sel)
        IdxDir:   PRDATA = dir_q;
        IdxOut:   PRDATA = out_q;
        IdxIn:    PRDATA = in_q;
        IdxTtype: PRDATA = ttype_q;
        IdxTlvl0: PRDATA = tlvl0_q;
        IdxTlvl1: PRDATA = tlvl1_q;
        IdxTstat: PRDATA = tstat_q;
        IdxIrqen: PRDATA = irqen_q;
        default:  PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped;

  assign gpio_oe = dir_q;
  assign gpio_o  = out_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_peripheral_gpio_apb4.sv
module tb_peripheral_gpio_apb4;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic          PWRITE = 1'b0;
  logic [0:0]    PSTRB = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [DW-1:0] gpio_i = '0;
  logic [DW-1:0] gpio_o;
  logic [DW-1:0] gpio_oe;
  logic          irq_o;

  int n_checks = 0;
  int n_fails  = 0;
  logic [DW-1:0] exp_q[$];

  peripheral_gpio_apb4 #(
    .PADDR_SIZE(AW),
    .PDATA_SIZE(DW)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PSTRB  (PSTRB),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .irq_o  (irq_o)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns 1 ns after the commit edge; err/rdy are sampled in the access phase.
  task automatic apb_write(input int idx, input logic [DW-1:0] data, input logic strb,
                           output logic err, output logic rdy);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = idx[AW-1:0]; PWDATA = data; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    err = PSLVERR;
    rdy = PREADY;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
  endtask

  task automatic apb_read(input int idx, output logic [DW-1:0] data, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = idx[AW-1:0];
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    data = PRDATA;
    err  = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd, exp;
    logic err;
    repeat (2) @(posedge PCLK);
    #1;
    n_checks++;
    if (gpio_o !== 8'h00 || gpio_oe !== 8'h00 || irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs_in_reset: got o=%h oe=%h irq=%b want 00 00 0",
               gpio_o, gpio_oe, irq_o);
    end
    PRESETn = 1'b1;
    // Start a write to OUT and abort it with reset during the access phase.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd1; PWDATA = 8'hA5; PSTRB = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h00);
      apb_read(i, rd, err);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) begin
        n_fails++;
        $display("FAIL reset_read_idx%0d: got %h want %h", i, rd, exp);
      end
    end
    n_checks++;
    if (gpio_o !== 8'h00 || gpio_oe !== 8'h00 || irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs_after: got o=%h oe=%h irq=%b want 00 00 0",
               gpio_o, gpio_oe, irq_o);
    end
  endtask

  task automatic test_basic_rw();
    logic [DW-1:0] rd, exp;
    logic err, rdy;
    apb_write(0, 8'hF0, 1'b1, err, rdy);
    n_checks++;
    if (gpio_oe !== 8'hF0 || err !== 1'b0 || rdy !== 1'b1) begin
      n_fails++;
      $display("FAIL write_dir: got oe=%h err=%b rdy=%b want F0 0 1", gpio_oe, err, rdy);
    end
    apb_write(1, 8'h5A, 1'b1, err, rdy);
    n_checks++;
    if (gpio_o !== 8'h5A || err !== 1'b0 || rdy !== 1'b1) begin
      n_fails++;
      $display("FAIL write_out: got o=%h err=%b rdy=%b want 5A 0 1", gpio_o, err, rdy);
    end
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 2; i++) begin
      apb_read(i, rd, err);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp || err !== 1'b0 || PREADY !== 1'b1) begin
        n_fails++;
        $display("FAIL readback_idx%0d: got %h err=%b want %h err=0", i, rd, err, exp);
      end
    end
  endtask

  task automatic test_strobe_ro_err();
    logic [DW-1:0] rd, exp;
    logic err, rdy;
    gpio_i = 8'h3C;
    apb_write(1, 8'hFF, 1'b0, err, rdy);
    exp_q.push_back(8'h5A);
    apb_read(1, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp || gpio_o !== exp) begin
      n_fails++;
      $display("FAIL strobe_zero: got OUT=%h gpio_o=%h want %h", rd, gpio_o, exp);
    end
    apb_write(2, 8'h33, 1'b1, err, rdy);
    exp_q.push_back(8'h3C);
    apb_read(2, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp || err !== 1'b0) begin
      n_fails++;
      $display("FAIL write_in_ignored: got IN=%h err=%b want %h err=0", rd, err, exp);
    end
    apb_write(9, 8'hFF, 1'b1, err, rdy);
    n_checks++;
    if (err !== 1'b1) begin
      n_fails++;
      $display("FAIL unmapped_write_err: got %b want 1", err);
    end
    apb_read(9, rd, err);
    n_checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin
      n_fails++;
      $display("FAIL unmapped_read: got data=%h err=%b want 00 1", rd, err);
    end
    // Index 9 aliases nothing: DIR/OUT/IRQEN must be unchanged.
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 2; i++) begin
      apb_read(i, rd, err);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) begin
        n_fails++;
        $display("FAIL unmapped_no_side_effect_idx%0d: got %h want %h", i, rd, exp);
      end
    end
    exp_q.push_back(8'h00);
    apb_read(7, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_fails++;
      $display("FAIL unmapped_no_side_effect_irqen: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_input_sync();
    logic [DW-1:0] exp;
    gpio_i = 8'h00;
    repeat (4) @(posedge PCLK);
    #1;
    // Hold a read of IN and watch PRDATA edge by edge.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'd2;
    gpio_i = 8'h81;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h81);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge PCLK); #1;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (PRDATA !== exp) begin
        n_fails++;
        $display("FAIL input_sync_step%0d: got %h want %h", k, PRDATA, exp);
      end
    end
    PSEL = 1'b0;
    gpio_i = 8'h00;
    repeat (4) @(posedge PCLK);
  endtask

  task automatic test_edge_irq();
    logic [DW-1:0] rd, exp;
    logic err, rdy;
    apb_write(3, 8'h01, 1'b1, err, rdy);
    apb_write(5, 8'h01, 1'b1, err, rdy);
    apb_write(7, 8'h01, 1'b1, err, rdy);
    @(posedge PCLK); #1;
    gpio_i[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge PCLK); #1;
      n_checks++;
      if (irq_o !== (k == 3)) begin
        n_fails++;
        $display("FAIL edge_irq_latency_edge%0d: got %b want %b", k + 1, irq_o, (k == 3));
      end
      if (k == 2) gpio_i[0] = 1'b0;
    end
    exp_q.push_back(8'h01);
    apb_read(6, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_fails++;
      $display("FAIL edge_tstat: got %h want %h", rd, exp);
    end
    apb_write(6, 8'h01, 1'b1, err, rdy);
    @(posedge PCLK); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL edge_irq_clear: got %b want 0", irq_o);
    end
    exp_q.push_back(8'h00);
    apb_read(6, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_fails++;
      $display("FAIL edge_tstat_clear: got %h want %h", rd, exp);
    end
    // Raise the input with rising trigger disabled, re-enable, then fall only.
    apb_write(5, 8'h00, 1'b1, err, rdy);
    gpio_i[0] = 1'b1;
    repeat (4) @(posedge PCLK);
    apb_write(5, 8'h01, 1'b1, err, rdy);
    gpio_i[0] = 1'b0;
    repeat (4) @(posedge PCLK);
    exp_q.push_back(8'h00);
    apb_read(6, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp || irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL edge_fall_only: got tstat=%h irq=%b want %h 0", rd, irq_o, exp);
    end
  endtask

  task automatic test_level_collision();
    logic [DW-1:0] rd, exp;
    logic err, rdy;
    apb_write(7, 8'h00, 1'b1, err, rdy);
    apb_write(5, 8'h00, 1'b1, err, rdy);
    apb_write(3, 8'h00, 1'b1, err, rdy);
    gpio_i = 8'h00;
    apb_write(4, 8'h02, 1'b1, err, rdy);
    repeat (2) @(posedge PCLK);
    apb_write(6, 8'h02, 1'b1, err, rdy);
    exp_q.push_back(8'h02);
    apb_read(6, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp || irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL level_set_wins: got tstat=%h irq=%b want %h 0", rd, irq_o, exp);
    end
    gpio_i[1] = 1'b1;
    repeat (4) @(posedge PCLK);
    apb_write(6, 8'h02, 1'b1, err, rdy);
    exp_q.push_back(8'h00);
    apb_read(6, rd, err);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp || irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL level_clear: got tstat=%h irq=%b want %h 0", rd, irq_o, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_strobe_ro_err();
    test_input_sync();
    test_edge_irq();
    test_level_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/peripheral_gpio_apb4.md
Name: peripheral_gpio_apb4

Overview:
- AMBA4 APB slave GPIO peripheral: PDATA_SIZE-bit general-purpose I/O port with direction control, an input synchroniser and per-bit level/edge interrupt triggers.
- Sits directly downstream of the APB4 bus-functional-model master in the peripheral bench, and of the system APB bridge in the MPSoC.
- Drives gpio_o/gpio_oe toward pads and samples gpio_i.
- Raises irq_o on enabled trigger events.

Parameters:
- PADDR_SIZE, 4, APB address width; must be >= 3 + log2(PDATA_SIZE/8).
- PDATA_SIZE, 8, APB data width and GPIO width; multiple of 8.

Ports:
- PCLK  input  1  clock; all state changes on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PADDR  input  PADDR_SIZE  byte address.
- PWRITE  input  1  1=write, 0=read.
- PSTRB  input  PDATA_SIZE/8  write byte strobes.
- PWDATA  input  PDATA_SIZE  write data.
- PRDATA  output  PDATA_SIZE  read data.
- PREADY  output  1  transfer ready.
- PSLVERR  output  1  transfer error.
- gpio_i  input  PDATA_SIZE  asynchronous pad inputs.
- gpio_o  output  PDATA_SIZE  pad output values.
- gpio_oe  output  PDATA_SIZE  pad output enables, 1=drive.
- irq_o  output  1  interrupt request.

Behaviour:
- Clock/reset:
  - Single clock PCLK; asynchronous active-low reset PRESETn.
  - While PRESETn=0, all registers, synchroniser flops, gpio_o, gpio_oe and irq_o are 0.
  - Reset asserted mid-transfer aborts it; no register is written.
- Register index: idx = PADDR >> log2(PDATA_SIZE/8). Map:
  - 0 DIR (RW)
  - 1 OUT (RW)
  - 2 IN (RO)
  - 3 TTYPE (RW; 0=level, 1=edge)
  - 4 TLVL0 (RW; low-level/falling enable)
  - 5 TLVL1 (RW; high-level/rising enable)
  - 6 TSTAT (R/W1C)
  - 7 IRQEN (RW)
  - idx >= 8 is unmapped.
- APB handshake:
  - PREADY is constant 1: zero wait states, every access completes in its first access-phase cycle.
  - Write commits at the rising edge where PSEL & PENABLE & PWRITE = 1.
  - Only byte lanes with PSTRB[i]=1 are updated.
  - Writes to IN are ignored, with no error.
- Read data:
  - PRDATA is combinational from the selected register while PSEL=1 and PWRITE=0; otherwise 0.
  - Unmapped reads return 0.
- PSLVERR is combinational: 1 during the access phase (PSEL & PENABLE) of an unmapped access, otherwise 0. An erroring write changes no state.
- Outputs: gpio_oe = DIR and gpio_o = OUT, both direct register outputs. New values are visible the cycle after the write edge.
- Input path:
  - Two-flop synchroniser, then IN register (sync2).
  - A gpio_i change before edge N is readable in IN after edge N+1.
  - prev_in holds IN delayed one cycle.
  - rise = IN & ~prev_in; fall = ~IN & prev_in.
- Trigger set, per bit, registered:
  - TTYPE=0: set = (TLVL1 & IN) | (TLVL0 & ~IN).
  - TTYPE=1: set = (TLVL1 & rise) | (TLVL0 & fall).
  - Set bits OR into TSTAT on the next edge.
- TSTAT clear:
  - Writing 1 clears that bit; writing 0 has no effect.
  - A set and a W1C clear on the same edge leave the bit set (set wins).
  - A level trigger still active re-sets immediately after the clear.
- Interrupt: irq_o is a register, updated every edge with |(TSTAT & IRQEN). Latency from a pad edge to irq_o is 4 PCLK edges:
  - 2 synchroniser edges
  - 1 edge for TSTAT
  - 1 edge for irq_o
- Changing TTYPE/TLVL does not clear TSTAT.
- prev_in resets to 0, so an input high at reset release with TTYPE=1, TLVL1=1 produces one rising event.

Test Plan:
- Reset: assert PRESETn=0 mid-write to OUT with data 0xA5 -> after release, all reads return 0x00; gpio_o=0x00, gpio_oe=0x00, irq_o=0.
- Basic read/write:
  - Write DIR=0xF0 and OUT=0x5A -> gpio_oe=0xF0 and gpio_o=0x5A one cycle after each access.
  - Readback returns 0xF0 and 0x5A, with PREADY=1 and PSLVERR=0 on every access.
- Strobe/RO/error:
  - Write OUT=0xFF with PSTRB=0 -> OUT unchanged.
  - Write IN=0x33 -> IN still reflects gpio_i.
  - Read and write at idx 9 -> PSLVERR=1 in the access phase, PRDATA=0x00, no state change.
- Input sync: gpio_i 0x00 -> 0x81 -> IN reads 0x00 until 2 edges have passed, then 0x81.
- Edge IRQ:
  - Setup: TTYPE=0x01, TLVL1=0x01, IRQEN=0x01; pulse gpio_i[0] high for 3 cycles.
  - Expected: TSTAT=0x01, irq_o=1 exactly 4 edges after the rise.
  - Write TSTAT=0x01 -> TSTAT=0x00 and irq_o=0 the following cycle.
  - A falling edge alone does not set TSTAT.
- Level IRQ and collision:
  - Setup: TTYPE=0x00, TLVL0=0x02, gpio_i[1]=0.
  - W1C of TSTAT bit 1 -> bit remains 1 (set wins).
  - Drive gpio_i[1]=1, then W1C -> TSTAT=0x00.
  - With IRQEN=0x00 throughout, irq_o stays 0.
